mod_updown_counter: RTL

//  Parametrised up/down modulo counter; the next generation of the team's free-running 3-bit counter.

---
 rtl/mod_updown_counter.sv | 83 ++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with enable, parallel load, programmable modulus,
// wrap or saturate at the range ends, a registered carry pulse and a sticky overflow flag.
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  generate
    if (WIDTH < 2 || MODULUS < 2 || MODULUS > (2 ** WIDTH) || SATURATE < 0 || SATURATE > 1) begin : g_bad_params
      $error("mod_updown_counter: illegal WIDTH/MODULUS/SATURATE combination");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] load_clamped;
  logic             at_top, at_bottom;

  // Out-of-range load values are pinned to the top of the count range.
  assign load_clamped = (load_val > CNT_MAX) ? CNT_MAX : load_val;
  assign at_top       = (cnt_q == CNT_MAX);
  assign at_bottom    = (cnt_q == '0);

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    if (load) begin
      cnt_d = load_clamped;
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
          carry_d = 1'b1;
          cnt_d   = (SATURATE != 0) ? cnt_q : '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (at_bottom) begin
          carry_d = 1'b1;
          cnt_d   = (SATURATE != 0) ? cnt_q : CNT_MAX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end
  end

  // A new carry event takes precedence over a simultaneous clear request.
  assign ovf_d = carry_d | (ovf_q & ~clr_ovf);

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out   = cnt_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;

endmodule
